// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Brief    : Bundles the icache, dcache and downstream memory handshakes
//             seen by mem_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  icache_cmd_valid;
  logic                  icache_cmd_ready;
  logic [ADDR_W-1:0]     icache_cmd_payload_addr;
  logic                  icache_rsp_valid;
  logic [31:0]           icache_rsp_payload_data;

  logic                  dcache_cmd_valid;
  logic                  dcache_cmd_ready;
  logic [ADDR_W-1:0]     dcache_cmd_payload_addr;
  logic                  dcache_cmd_payload_wen;
  logic [DATA_W-1:0]     dcache_cmd_payload_wdata;
  logic [DATA_W/8-1:0]   dcache_cmd_payload_wstrb;
  logic                  dcache_rsp_valid;
  logic [DATA_W-1:0]     dcache_rsp_payload_data;

  logic                  mem_cmd_valid;
  logic                  mem_cmd_ready;
  logic [ADDR_W-1:0]     mem_cmd_addr;
  logic                  mem_cmd_wen;
  logic [DATA_W-1:0]     mem_cmd_wdata;
  logic [DATA_W/8-1:0]   mem_cmd_wstrb;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rsp_data;

  // Arbiter side
  modport slave (
    input  icache_cmd_valid, icache_cmd_payload_addr,
    output icache_cmd_ready, icache_rsp_valid, icache_rsp_payload_data,
    input  dcache_cmd_valid, dcache_cmd_payload_addr, dcache_cmd_payload_wen,
    input  dcache_cmd_payload_wdata, dcache_cmd_payload_wstrb,
    output dcache_cmd_ready, dcache_rsp_valid, dcache_rsp_payload_data,
    output mem_cmd_valid, mem_cmd_addr, mem_cmd_wen, mem_cmd_wdata, mem_cmd_wstrb,
    input  mem_cmd_ready, mem_rsp_valid, mem_rsp_data
  );

  // Core and memory side
  modport master (
    output icache_cmd_valid, icache_cmd_payload_addr,
    input  icache_cmd_ready, icache_rsp_valid, icache_rsp_payload_data,
    output dcache_cmd_valid, dcache_cmd_payload_addr, dcache_cmd_payload_wen,
    output dcache_cmd_payload_wdata, dcache_cmd_payload_wstrb,
    input  dcache_cmd_ready, dcache_rsp_valid, dcache_rsp_payload_data,
    input  mem_cmd_valid, mem_cmd_addr, mem_cmd_wen, mem_cmd_wdata, mem_cmd_wstrb,
    output mem_cmd_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one single-outstanding memory port between icache and
//             dcache; define MEM_ARB_RR_EN for round-robin, else dcache wins.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mem_port_arbiter_if.slave bus,
  output logic              err_stray_rsp
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic c_icache = 1'b0;
  localparam logic c_dcache = 1'b1;

  state_t              r_state;
  logic                r_owner;
  logic                r_half;

  logic                w_idle;
  logic                w_sel_d;
  logic                w_issue;
  logic                w_fire;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic [DATA_W-1:0]   w_cmd_wdata;
  logic [DATA_W/8-1:0] w_cmd_wstrb;
  logic [31:0]         w_rsp_word;

`ifdef MEM_ARB_RR_EN
  logic r_rr_ptr;

  // Under contention the pointer decides; a lone requester always wins.
  assign w_sel_d = bus.dcache_cmd_valid &
                   (~bus.icache_cmd_valid | (r_rr_ptr == c_dcache));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= c_icache;
    end else if (w_fire) begin
      r_rr_ptr <= w_sel_d ? c_icache : c_dcache;
    end
  end
`else
  assign w_sel_d = bus.dcache_cmd_valid;
`endif

  assign w_idle  = (r_state == IDLE);
  assign w_issue = w_idle & (bus.icache_cmd_valid | bus.dcache_cmd_valid);
  assign w_fire  = w_issue & bus.mem_cmd_ready;

  // Payload follows the current winner every cycle until the handshake.
  assign w_cmd_addr  = w_sel_d ? bus.dcache_cmd_payload_addr : bus.icache_cmd_payload_addr;
  assign w_cmd_wdata = w_sel_d ? bus.dcache_cmd_payload_wdata : '0;
  assign w_cmd_wstrb = w_sel_d ? bus.dcache_cmd_payload_wstrb : '0;

  assign bus.mem_cmd_valid = w_issue;
  assign bus.mem_cmd_addr  = w_cmd_addr;
  assign bus.mem_cmd_wen   = w_sel_d & bus.dcache_cmd_payload_wen;
  assign bus.mem_cmd_wdata = w_cmd_wdata;
  assign bus.mem_cmd_wstrb = w_cmd_wstrb;

  assign bus.icache_cmd_ready = w_idle & ~w_sel_d & bus.icache_cmd_valid & bus.mem_cmd_ready;
  assign bus.dcache_cmd_ready = w_idle & w_sel_d & bus.mem_cmd_ready;

  assign w_rsp_word = r_half ? bus.mem_rsp_data[63:32] : bus.mem_rsp_data[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state                     <= IDLE;
      r_owner                     <= c_icache;
      r_half                      <= 1'b0;
      bus.icache_rsp_valid        <= 1'b0;
      bus.icache_rsp_payload_data <= '0;
      bus.dcache_rsp_valid        <= 1'b0;
      bus.dcache_rsp_payload_data <= '0;
      err_stray_rsp               <= 1'b0;
    end else begin
      bus.icache_rsp_valid <= 1'b0;
      bus.dcache_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.mem_rsp_valid) begin
            err_stray_rsp <= 1'b1;
          end
          if (w_fire) begin
            r_owner <= w_sel_d ? c_dcache : c_icache;
            r_half  <= bus.icache_cmd_payload_addr[2];
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_rsp_valid) begin
            if (r_owner == c_dcache) begin
              bus.dcache_rsp_valid        <= 1'b1;
              bus.dcache_rsp_payload_data <= bus.mem_rsp_data;
            end else begin
              bus.icache_rsp_valid        <= 1'b1;
              bus.icache_rsp_payload_data <= w_rsp_word;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Self-checking bench: directed vector table, corner sequences and
//             randomized traffic against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic err_stray_rsp;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .err_stray_rsp (err_stray_rsp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    bit is_d;
    bit is_wr;
    bit half;
  } txn_t;

  txn_t        m_out[$];
  int          m_grants;
  bit          m_last_d;
  bit          m_err;
  bit          m_irv, m_drv;
  logic [31:0] m_idata;
  logic [63:0] m_ddata;
  bit          m_ddata_known;
  bit          g_fire, g_dut_gi, g_dut_gd;
  int          mem_cnt = -1;

  function automatic void model_reset();
    m_out.delete();
    m_grants      = 0;
    m_last_d      = 1'b0;
    m_err         = 1'b0;
    m_irv         = 1'b0;
    m_drv         = 1'b0;
    m_idata       = '0;
    m_ddata       = '0;
    m_ddata_known = 1'b1;
  endfunction

  // Which requester the rules say wins this cycle.
  function automatic bit pick_d(input bit iv, input bit dv);
    if (iv && dv) begin
`ifdef MEM_ARB_RR_EN
      return (m_grants == 0) ? 1'b0 : !m_last_d;
`else
      return 1'b1;
`endif
    end
    return dv;
  endfunction

  task automatic cycle();
    bit          idle, pd, exp_mv, rv;
    logic [63:0] rd;
    txn_t        t, t_new;
    #1;
    idle   = (m_out.size() == 0);
    pd     = pick_d(bus.icache_cmd_valid, bus.dcache_cmd_valid);
    exp_mv = idle && (bus.icache_cmd_valid || bus.dcache_cmd_valid);
    chk("mem_cmd_valid", {63'd0, bus.mem_cmd_valid}, {63'd0, exp_mv});
    if (exp_mv) begin
      chk("mem_cmd_addr", bus.mem_cmd_addr,
          pd ? bus.dcache_cmd_payload_addr : bus.icache_cmd_payload_addr);
      chk("mem_cmd_wen", {63'd0, bus.mem_cmd_wen}, {63'd0, pd && bus.dcache_cmd_payload_wen});
      chk("mem_cmd_wdata", bus.mem_cmd_wdata, pd ? bus.dcache_cmd_payload_wdata : 64'd0);
      chk("mem_cmd_wstrb", {56'd0, bus.mem_cmd_wstrb}, {56'd0, pd ? bus.dcache_cmd_payload_wstrb : 8'd0});
    end
    chk("icache_cmd_ready", {63'd0, bus.icache_cmd_ready},
        {63'd0, exp_mv && !pd && bus.mem_cmd_ready});
    chk("dcache_cmd_ready", {63'd0, bus.dcache_cmd_ready},
        {63'd0, exp_mv && pd && bus.mem_cmd_ready});
    g_fire   = exp_mv && bus.mem_cmd_ready;
    g_dut_gi = bus.icache_cmd_ready;
    g_dut_gd = bus.dcache_cmd_ready;
    rv       = bus.mem_rsp_valid;
    rd       = bus.mem_rsp_data;
    t_new    = '{pd, pd && bus.dcache_cmd_payload_wen, bus.icache_cmd_payload_addr[2]};
    @(posedge clk);
    m_irv = 1'b0;
    m_drv = 1'b0;
    if (!idle && rv) begin
      t = m_out.pop_front();
      if (t.is_d) begin
        m_drv = 1'b1;
        if (t.is_wr) m_ddata_known = 1'b0;
        else begin
          m_ddata       = rd;
          m_ddata_known = 1'b1;
        end
      end else begin
        m_irv   = 1'b1;
        m_idata = t.half ? rd[63:32] : rd[31:0];
      end
    end else if (idle && rv) begin
      m_err = 1'b1;
    end
    if (g_fire) begin
      m_out.push_back(t_new);
      m_grants++;
      m_last_d = pd;
    end
    #1;
    chk("icache_rsp_valid", {63'd0, bus.icache_rsp_valid}, {63'd0, m_irv});
    chk("icache_rsp_data", {32'd0, bus.icache_rsp_payload_data}, {32'd0, m_idata});
    chk("dcache_rsp_valid", {63'd0, bus.dcache_rsp_valid}, {63'd0, m_drv});
    if (m_ddata_known) chk("dcache_rsp_data", bus.dcache_rsp_payload_data, m_ddata);
    chk("err_stray_rsp", {63'd0, err_stray_rsp}, {63'd0, m_err});
  endtask

  // Downstream memory: answers each command after a programmable delay.
  task automatic mem_pre();
    if (mem_cnt == 0) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = {$urandom, $urandom};
      mem_cnt           = -1;
    end else begin
      bus.mem_rsp_valid = 1'b0;
      if (mem_cnt > 0) mem_cnt--;
    end
  endtask

  task automatic mem_post(input int maxd);
    if (g_fire) mem_cnt = int'($urandom_range(maxd, 0));
  endtask

  task automatic step(input int maxd);
    mem_pre();
    cycle();
    mem_post(maxd);
  endtask

  task automatic set_idle();
    bus.icache_cmd_valid         = 1'b0;
    bus.icache_cmd_payload_addr  = '0;
    bus.dcache_cmd_valid         = 1'b0;
    bus.dcache_cmd_payload_addr  = '0;
    bus.dcache_cmd_payload_wen   = 1'b0;
    bus.dcache_cmd_payload_wdata = '0;
    bus.dcache_cmd_payload_wstrb = '0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    mem_cnt = -1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iv;   logic [63:0] ia;
    logic        dv;   logic [63:0] da;  logic dwen; logic [63:0] dwd; logic [7:0] dws;
    logic        mrdy; logic        mrv; logic [63:0] mrd;
    logic        e_mv; logic [63:0] e_ma; logic e_mwen; logic [63:0] e_mwd; logic [7:0] e_mws;
    logic        e_ir; logic        e_dr;
    logic        e_irv; logic [31:0] e_ird;
    logic        e_drv; logic [63:0] e_drd; logic e_dchk;
    logic        e_err;
  } vec_t;

  localparam logic        T   = 1'b1;
  localparam logic        F   = 1'b0;
  localparam logic [63:0] Z64 = 64'h0;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [7:0]  Z8  = 8'h0;
  localparam logic [63:0] A1  = 64'h0000_0000_8000_0004;
  localparam logic [63:0] A0  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DA  = 64'h0000_0000_8000_0010;
  localparam logic [63:0] DW  = 64'hDEAD_BEEF_0000_0000;
  localparam logic [63:0] RD1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] RD2 = 64'hCAFE_BABE_1234_5678;
  localparam logic [63:0] RD3 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [31:0] W1  = 32'h1122_3344;
  localparam logic [31:0] W3  = 32'hCCCC_DDDD;
  localparam int          NV  = 13;

  vec_t vt [NV];
  int   gq[$];

  initial begin
    vt[0]  = '{T,A1,  F,Z64,F,Z64,Z8,  T,F,Z64,  T,A1,F,Z64,Z8,  T,F,  F,Z32,  F,Z64,T,  F};
    vt[1]  = '{F,Z64, F,Z64,F,Z64,Z8,  T,F,Z64,  F,Z64,F,Z64,Z8, F,F,  F,Z32,  F,Z64,T,  F};
    vt[2]  = vt[1];
    vt[3]  = '{F,Z64, F,Z64,F,Z64,Z8,  T,T,RD1,  F,Z64,F,Z64,Z8, F,F,  T,W1,   F,Z64,T,  F};
    vt[4]  = '{F,Z64, F,Z64,F,Z64,Z8,  T,F,Z64,  F,Z64,F,Z64,Z8, F,F,  F,W1,   F,Z64,T,  F};
    vt[5]  = '{F,Z64, T,DA,T,DW,8'hF0, T,F,Z64,  T,DA,T,DW,8'hF0, F,T, F,W1,   F,Z64,T,  F};
    vt[6]  = '{F,Z64, F,Z64,F,Z64,Z8,  T,T,64'h0BAD, F,Z64,F,Z64,Z8, F,F, F,W1, T,Z64,F,  F};
    vt[7]  = '{F,Z64, T,64'h100,F,64'h5555,8'hFF, T,F,Z64, T,64'h100,F,64'h5555,8'hFF, F,T, F,W1, F,Z64,F, F};
    vt[8]  = '{T,A0,  F,Z64,F,Z64,Z8,  T,T,RD2,  F,Z64,F,Z64,Z8, F,F,  F,W1,   T,RD2,T,  F};
    vt[9]  = '{T,A0,  F,Z64,F,Z64,Z8,  T,F,Z64,  T,A0,F,Z64,Z8,  T,F,  F,W1,   F,RD2,T,  F};
    vt[10] = '{F,Z64, F,Z64,F,Z64,Z8,  T,T,RD3,  F,Z64,F,Z64,Z8, F,F,  T,W3,   F,RD2,T,  F};
    vt[11] = '{F,Z64, F,Z64,F,Z64,Z8,  T,T,64'h77, F,Z64,F,Z64,Z8, F,F, F,W3,  F,RD2,T,  T};
    vt[12] = '{F,Z64, F,Z64,F,Z64,Z8,  T,F,Z64,  F,Z64,F,Z64,Z8, F,F,  F,W3,   F,RD2,T,  T};

    rst_n = 1'b0;
    set_idle();
    bus.mem_cmd_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Reset state
    #1;
    chk("reset_irsp_valid", {63'd0, bus.icache_rsp_valid}, 64'd0);
    chk("reset_drsp_valid", {63'd0, bus.dcache_rsp_valid}, 64'd0);
    chk("reset_irsp_data", {32'd0, bus.icache_rsp_payload_data}, 64'd0);
    chk("reset_drsp_data", bus.dcache_rsp_payload_data, 64'd0);
    chk("reset_err", {63'd0, err_stray_rsp}, 64'd0);
    chk("reset_mem_cmd_valid", {63'd0, bus.mem_cmd_valid}, 64'd0);
    @(posedge clk);
    #1;

    for (int k = 0; k < NV; k++) begin
      bus.icache_cmd_valid         = vt[k].iv;
      bus.icache_cmd_payload_addr  = vt[k].ia;
      bus.dcache_cmd_valid         = vt[k].dv;
      bus.dcache_cmd_payload_addr  = vt[k].da;
      bus.dcache_cmd_payload_wen   = vt[k].dwen;
      bus.dcache_cmd_payload_wdata = vt[k].dwd;
      bus.dcache_cmd_payload_wstrb = vt[k].dws;
      bus.mem_cmd_ready            = vt[k].mrdy;
      bus.mem_rsp_valid            = vt[k].mrv;
      bus.mem_rsp_data             = vt[k].mrd;
      #1;
      chk($sformatf("vec%0d_mem_cmd_valid", k), {63'd0, bus.mem_cmd_valid}, {63'd0, vt[k].e_mv});
      if (vt[k].e_mv) begin
        chk($sformatf("vec%0d_mem_cmd_addr", k), bus.mem_cmd_addr, vt[k].e_ma);
        chk($sformatf("vec%0d_mem_cmd_wen", k), {63'd0, bus.mem_cmd_wen}, {63'd0, vt[k].e_mwen});
        chk($sformatf("vec%0d_mem_cmd_wdata", k), bus.mem_cmd_wdata, vt[k].e_mwd);
        chk($sformatf("vec%0d_mem_cmd_wstrb", k), {56'd0, bus.mem_cmd_wstrb}, {56'd0, vt[k].e_mws});
      end
      chk($sformatf("vec%0d_icache_ready", k), {63'd0, bus.icache_cmd_ready}, {63'd0, vt[k].e_ir});
      chk($sformatf("vec%0d_dcache_ready", k), {63'd0, bus.dcache_cmd_ready}, {63'd0, vt[k].e_dr});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_irsp_valid", k), {63'd0, bus.icache_rsp_valid}, {63'd0, vt[k].e_irv});
      chk($sformatf("vec%0d_irsp_data", k), {32'd0, bus.icache_rsp_payload_data}, {32'd0, vt[k].e_ird});
      chk($sformatf("vec%0d_drsp_valid", k), {63'd0, bus.dcache_rsp_valid}, {63'd0, vt[k].e_drv});
      if (vt[k].e_dchk)
        chk($sformatf("vec%0d_drsp_data", k), bus.dcache_rsp_payload_data, vt[k].e_drd);
      chk($sformatf("vec%0d_err", k), {63'd0, err_stray_rsp}, {63'd0, vt[k].e_err});
    end

    set_idle();
    bus.mem_rsp_valid = 1'b0;
    do_reset();
    chk("reset_clears_err", {63'd0, err_stray_rsp}, 64'd0);

    // Contention: both requesters valid for four transactions
    bus.icache_cmd_valid        = 1'b1;
    bus.icache_cmd_payload_addr = A1;
    bus.dcache_cmd_valid        = 1'b1;
    bus.dcache_cmd_payload_addr = 64'h2000;
    bus.mem_cmd_ready           = 1'b1;
    for (int c = 0; c < 40 && gq.size() < 4; c++) begin
      mem_pre();
      cycle();
      chk("contention_both_ready", {63'd0, g_dut_gi & g_dut_gd}, 64'd0);
      if (g_dut_gd) gq.push_back(1);
      else if (g_dut_gi) gq.push_back(0);
      mem_post(0);
    end
    chk("contention_grant_count", 64'(gq.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < gq.size()) begin
`ifdef MEM_ARB_RR_EN
        chk($sformatf("contention_grant%0d_is_dcache", k), 64'(gq[k]), 64'(k % 2));
`else
        chk($sformatf("contention_grant%0d_is_dcache", k), 64'(gq[k]), 64'd1);
`endif
      end
    end
    set_idle();
    repeat (4) step(0);

    // Backpressure: command held with stable payload until accepted
    bus.icache_cmd_valid        = 1'b1;
    bus.icache_cmd_payload_addr = 64'h8000_0008;
    bus.mem_cmd_ready           = 1'b0;
    repeat (5) begin
      step(2);
      chk("bp_valid_held", {63'd0, bus.mem_cmd_valid}, 64'd1);
      chk("bp_addr_stable", bus.mem_cmd_addr, 64'h8000_0008);
    end
    bus.mem_cmd_ready = 1'b1;
    step(2);
    chk("bp_busy_after_accept", {63'd0, bus.mem_cmd_valid}, 64'd0);
    bus.icache_cmd_valid = 1'b0;
    repeat (6) step(2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.icache_cmd_valid         = ($urandom_range(2, 0) != 0);
      bus.icache_cmd_payload_addr  = {$urandom, $urandom};
      bus.dcache_cmd_valid         = ($urandom_range(2, 0) != 0);
      bus.dcache_cmd_payload_addr  = {$urandom, $urandom};
      bus.dcache_cmd_payload_wen   = $urandom_range(1, 0) == 1;
      bus.dcache_cmd_payload_wdata = {$urandom, $urandom};
      bus.dcache_cmd_payload_wstrb = 8'($urandom);
      bus.mem_cmd_ready            = ($urandom_range(3, 0) != 0);
      mem_pre();
      if (mem_cnt < 0 && m_out.size() == 0 && $urandom_range(199, 0) == 0) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = {$urandom, $urandom};
      end
      cycle();
      mem_post(3);
    end
    set_idle();
    repeat (8) step(3);

    // Asynchronous reset while a fetch is outstanding
    do_reset();
    bus.icache_cmd_valid        = 1'b1;
    bus.icache_cmd_payload_addr = A1;
    bus.mem_cmd_ready           = 1'b1;
    bus.mem_rsp_valid           = 1'b0;
    cycle();
    chk("rst_seq_fetch_granted", {63'd0, g_dut_gi}, 64'd1);
    bus.mem_cmd_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy_mem_cmd_valid_idle", {63'd0, bus.mem_cmd_valid}, 64'd1);
    chk("rst_busy_irsp_valid", {63'd0, bus.icache_rsp_valid}, 64'd0);
    chk("rst_busy_drsp_valid", {63'd0, bus.dcache_rsp_valid}, 64'd0);
    chk("rst_busy_irsp_data", {32'd0, bus.icache_rsp_payload_data}, 64'd0);
    chk("rst_busy_drsp_data", bus.dcache_rsp_payload_data, 64'd0);
    chk("rst_busy_err", {63'd0, err_stray_rsp}, 64'd0);
    bus.icache_cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    mem_cnt = -1;

    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'h5A5A;
    cycle();
    chk("late_rsp_sets_err", {63'd0, err_stray_rsp}, 64'd1);
    bus.mem_rsp_valid = 1'b0;

    bus.icache_cmd_valid        = 1'b1;
    bus.icache_cmd_payload_addr = A0;
    bus.mem_cmd_ready           = 1'b1;
    cycle();
    chk("post_rst_fetch_granted", {63'd0, g_dut_gi}, 64'd1);
    bus.icache_cmd_valid = 1'b0;
    cycle();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'h0123_4567_89AB_CDEF;
    cycle();
    chk("post_rst_fetch_valid", {63'd0, bus.icache_rsp_valid}, 64'd1);
    chk("post_rst_fetch_data", {32'd0, bus.icache_rsp_payload_data}, 64'h89AB_CDEF);
    bus.mem_rsp_valid = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
